// File: rtl/hfosc_seq_pkg.sv
// Shared definitions for the HF oscillator sequencer: state encodings,
// counter width and the power-cycle counter saturation helper.
package hfosc_seq_pkg;

   localparam int CNT_W = 8;
   localparam int PC_W  = 16;

   localparam logic [PC_W-1:0] PC_SAT = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_STANDBY = 3'd2,
      ST_ON      = 3'd3,
      ST_GATE    = 3'd4
   } hf_state_t;

   // Increment that sticks at the top value instead of wrapping to zero.
   function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] v);
      return (v == PC_SAT) ? v : v + {{(PC_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/hfosc_seq_if.sv
// PMU clock-request interface plus the oscillator pin / status outputs.
// master = PMU side (drives requests), slave = sequencer.
interface hfosc_seq_if;
   import hfosc_seq_pkg::*;

   logic            clkhf_powerup_req;
   logic            clkhf_enable_req;
   logic            hf_pu;
   logic            hf_en;
   logic            hf_ready;
   logic            seq_busy;
   logic [PC_W-1:0] power_cycles;

   modport master (
      output clkhf_powerup_req,
      output clkhf_enable_req,
      input  hf_pu,
      input  hf_en,
      input  hf_ready,
      input  seq_busy,
      input  power_cycles
   );

   modport slave (
      input  clkhf_powerup_req,
      input  clkhf_enable_req,
      output hf_pu,
      output hf_en,
      output hf_ready,
      output seq_busy,
      output power_cycles
   );

endinterface

// File: rtl/hfosc_seq_req_sync.sv
// Multi-flop synchroniser for one asynchronous request level.
module req_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic req_async,
   output logic req_s
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   // Shift the raw level in at the bottom of the chain.
   always_comb begin
      chain_d = {chain_q[STAGES-2:0], req_async};
   end

   // Chain flops, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) chain_q <= '0;
      else       chain_q <= chain_d;
   end

   assign req_s = chain_q[STAGES-1];

endmodule

// File: rtl/hfosc_seq.sv
// HF oscillator power sequencer. Consumes synchronised powerup/enable
// request levels and drives CLKHFPU / CLKHFEN with an enforced settle time
// before enable and an enable-off-before-power-down delay.
//
// state   | meaning
// --------+---------------------------------------------------------
// OFF     | oscillator unpowered, all outputs low
// SETTLE  | powered, waiting SETTLE_CYCLES before enable is allowed
// STANDBY | powered and settled, clock gated off
// ON      | powered, enabled, hf_ready high
// GATE    | enable removed, waiting OFF_DELAY before power-down
module hfosc_seq
   import hfosc_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int OFF_DELAY     = 2,
   parameter int SYNC_STAGES   = 2
) (
   input  logic        clk,
   input  logic        reset,
   hfosc_seq_if.slave  bus
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic pu_s;
   logic en_s;
   logic en_eff;

   hf_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             hf_pu_q, hf_pu_d;
   logic             hf_en_q, hf_en_d;
   logic             hf_ready_q, hf_ready_d;
   logic             busy_q, busy_d;

   req_sync #(.STAGES(SYNC_STAGES)) u_sync_pu (
      .clk       (clk),
      .reset     (reset),
      .req_async (bus.clkhf_powerup_req),
      .req_s     (pu_s)
   );

   req_sync #(.STAGES(SYNC_STAGES)) u_sync_en (
      .clk       (clk),
      .reset     (reset),
      .req_async (bus.clkhf_enable_req),
      .req_s     (en_s)
   );

   // An enable request only counts while powerup is also requested.
   assign en_eff = en_s & pu_s;

   // Next state, counter and power-cycle count; outputs decoded from the
   // next state so every pin is a flop and changes on the state edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;

      unique case (state_q)
         ST_OFF: begin
            if (pu_s) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LOAD;
               pc_d    = sat_inc(pc_q);
            end
         end
         ST_SETTLE: begin
            if (!pu_s) begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = en_eff ? ST_ON : ST_STANDBY;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_STANDBY: begin
            if (!pu_s) begin
               state_d = ST_GATE;
               cnt_d   = OFF_LOAD;
            end else if (en_eff) begin
               state_d = ST_ON;
            end
         end
         ST_ON: begin
            // Powerup drop wins over a simultaneous enable drop.
            if (!pu_s) begin
               state_d = ST_GATE;
               cnt_d   = OFF_LOAD;
            end else if (!en_eff) begin
               state_d = ST_STANDBY;
            end
         end
         ST_GATE: begin
            // Oscillator is still settled here, so a re-request skips SETTLE.
            if (pu_s) begin
               state_d = ST_STANDBY;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_OFF;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
         end
      endcase

      hf_pu_d    = (state_d != ST_OFF);
      hf_en_d    = (state_d == ST_ON);
      hf_ready_d = (state_d == ST_ON);
      busy_d     = (state_d == ST_SETTLE) || (state_d == ST_GATE);
   end

   // State, counters and registered outputs; reset wins in any state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_OFF;
         cnt_q      <= '0;
         pc_q       <= '0;
         hf_pu_q    <= 1'b0;
         hf_en_q    <= 1'b0;
         hf_ready_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         hf_pu_q    <= hf_pu_d;
         hf_en_q    <= hf_en_d;
         hf_ready_q <= hf_ready_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.hf_pu        = hf_pu_q;
   assign bus.hf_en        = hf_en_q;
   assign bus.hf_ready     = hf_ready_q;
   assign bus.seq_busy     = busy_q;
   assign bus.power_cycles = pc_q;

endmodule

// File: tb/tb_hfosc_seq.sv
// Bench for hfosc_seq: a behavioural model predicts the outputs after every
// clock edge and queues them; a monitor pops and compares on the falling
// edge. Directed scenarios add latency / count checks, then random traffic.
module tb_hfosc_seq;
   import hfosc_seq_pkg::*;

   localparam int SETTLE = 4;
   localparam int OFFD   = 2;
   localparam int SYNC   = 2;

   typedef struct packed {
      logic        pu;
      logic        en;
      logic        rdy;
      logic        busy;
      logic [15:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic sat_preload;

   hfosc_seq_if bus();

   hfosc_seq #(
      .SETTLE_CYCLES (SETTLE),
      .OFF_DELAY     (OFFD),
      .SYNC_STAGES   (SYNC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t sb_q[$];
   int   n_checks;
   int   n_fail;
   bit   started;

   // model state (abstract: powered / enabled flags and a remaining-time count)
   bit m_pu_h[SYNC];
   bit m_en_h[SYNC];
   bit m_pow, m_en, m_settling, m_gating;
   int m_rem;
   int m_cycles;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_loop();
      bit p, e;
      forever begin
         @(posedge clk);
         started = 1'b1;
         if (reset) begin
            for (int i = 0; i < SYNC; i++) begin
               m_pu_h[i] = 1'b0;
               m_en_h[i] = 1'b0;
            end
            m_pow = 0; m_en = 0; m_settling = 0; m_gating = 0;
            m_rem = 0; m_cycles = 0;
         end else begin
            if (sat_preload) m_cycles = 16'hFFFE;
            p = m_pu_h[SYNC-1];
            e = m_en_h[SYNC-1] & p;
            if (!m_pow) begin
               if (p) begin
                  m_pow = 1; m_settling = 1; m_rem = SETTLE - 1;
                  if (m_cycles < 65535) m_cycles++;
               end
            end else if (m_settling) begin
               if (!p) begin
                  m_pow = 0; m_settling = 0;
               end else if (m_rem == 0) begin
                  m_settling = 0; m_en = e;
               end else m_rem--;
            end else if (m_gating) begin
               if (p) m_gating = 0;
               else if (m_rem == 0) begin
                  m_gating = 0; m_pow = 0;
               end else m_rem--;
            end else if (m_en) begin
               if (!p) begin
                  m_en = 0; m_gating = 1; m_rem = OFFD - 1;
               end else if (!e) m_en = 0;
            end else begin
               if (!p) begin
                  m_gating = 1; m_rem = OFFD - 1;
               end else if (e) m_en = 1;
            end
            for (int i = SYNC - 1; i > 0; i--) begin
               m_pu_h[i] = m_pu_h[i-1];
               m_en_h[i] = m_en_h[i-1];
            end
            m_pu_h[0] = bus.clkhf_powerup_req;
            m_en_h[0] = bus.clkhf_enable_req;
         end
         sb_q.push_back('{pu: m_pow, en: m_en, rdy: m_en,
                          busy: (m_settling | m_gating), pc: m_cycles[15:0]});
      end
   endtask

   task automatic monitor_loop();
      exp_t e, a;
      forever begin
         @(negedge clk);
         if (started) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
            end else begin
               e = sb_q.pop_front();
               a = '{pu: bus.hf_pu, en: bus.hf_en, rdy: bus.hf_ready,
                     busy: bus.seq_busy, pc: bus.power_cycles};
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL outputs t=%0t: got pu/en/rdy/busy=%b%b%b%b pc=%h expected %b%b%b%b pc=%h",
                           $time, a.pu, a.en, a.rdy, a.busy, a.pc, e.pu, e.en, e.rdy, e.busy, e.pc);
               end
            end
            n_checks++;
            if (bus.hf_en && !bus.hf_pu) begin
               n_fail++;
               $display("FAIL en_without_pu: got hf_en=1 hf_pu=0 required not both (t=%0t)", $time);
            end
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic get_sig(input int sel);
      case (sel)
         0: return bus.hf_pu;
         1: return bus.hf_en;
         default: return bus.hf_ready;
      endcase
   endfunction

   // Waits up to 'limit' edges for the selected output to reach 'val'.
   // 'idx' is the 0-based number of the edge it was seen after.
   task automatic wait_sig(input string name, input int sel, input logic val,
                           input int limit, output int idx);
      bit ok;
      ok  = 0;
      idx = -1;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (get_sig(sel) == val) begin
            ok  = 1;
            idx = i;
            break;
         end
      end
      #1;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout after %0d edges waiting for %0b", name, limit, val);
      end
   endtask

   int i0, i1, hold;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      started  = 0;
      sat_preload = 0;
      reset = 1'b1;
      bus.clkhf_powerup_req = 1'b1;
      bus.clkhf_enable_req  = 1'b1;

      fork
         model_loop();
         monitor_loop();
      join_none

      // reset state, then release with both requests high
      step(3);
      chk("reset_hf_pu", bus.hf_pu, 0);
      chk("reset_power_cycles", bus.power_cycles, 0);
      reset = 1'b0;
      wait_sig("pu_rise", 0, 1'b1, 20, i0);
      chk("pu_rise_edge", i0, SYNC);
      wait_sig("en_rise", 1, 1'b1, 20, i1);
      chk("en_rise_edge", i0 + 1 + i1, SYNC + SETTLE);
      chk("ready_with_en", bus.hf_ready, 1);
      chk("pc_after_first", bus.power_cycles, 1);

      // drop powerup from ON
      bus.clkhf_powerup_req = 1'b0;
      wait_sig("en_fall", 1, 1'b0, 20, i0);
      chk("en_fall_edge", i0, SYNC);
      wait_sig("pu_fall", 0, 1'b0, 20, i1);
      chk("pu_fall_after_en", i1 + 1, OFFD);
      step(3);

      // abort during SETTLE, then full re-settle
      bus.clkhf_powerup_req = 1'b1;
      wait_sig("abort_pu_rise", 0, 1'b1, 20, i0);
      bus.clkhf_powerup_req = 1'b0;
      wait_sig("abort_pu_fall", 0, 1'b0, 20, i0);
      chk("abort_no_en", bus.hf_en, 0);
      chk("pc_after_abort", bus.power_cycles, 2);
      step(3);
      bus.clkhf_powerup_req = 1'b1;
      wait_sig("resettle_pu", 0, 1'b1, 20, i0);
      wait_sig("resettle_en", 1, 1'b1, 20, i1);
      chk("resettle_len", i1 + 1, SETTLE);
      chk("pc_after_resettle", bus.power_cycles, 3);

      // enable toggle while powered: STANDBY and back, no settle
      bus.clkhf_enable_req = 1'b0;
      wait_sig("standby_en_fall", 1, 1'b0, 20, i0);
      chk("standby_en_fall_edge", i0, SYNC);
      chk("standby_pu_held", bus.hf_pu, 1);
      step(2);
      bus.clkhf_enable_req = 1'b1;
      wait_sig("standby_en_rise", 1, 1'b1, 20, i0);
      chk("standby_en_rise_edge", i0, SYNC);
      chk("pc_after_toggle", bus.power_cycles, 3);

      // enable without powerup is ignored
      bus.clkhf_powerup_req = 1'b0;
      wait_sig("noreq_pu_fall", 0, 1'b0, 20, i0);
      step(30);
      chk("noreq_hf_pu", bus.hf_pu, 0);
      chk("noreq_hf_en", bus.hf_en, 0);

      // re-request during GATE goes back to STANDBY then ON
      bus.clkhf_powerup_req = 1'b1;
      wait_sig("gate_en_rise", 1, 1'b1, 30, i0);
      bus.clkhf_powerup_req = 1'b0;
      step(1);
      bus.clkhf_powerup_req = 1'b1;
      step(12);
      chk("gate_rereq_en", bus.hf_en, 1);
      chk("pc_after_gate_rereq", bus.power_cycles, 4);

      // saturation of power_cycles
      bus.clkhf_powerup_req = 1'b0;
      wait_sig("sat_pu_fall", 0, 1'b0, 20, i0);
      step(2);
      @(negedge clk);
      #1;
      force dut.pc_q = 16'hFFFE;
      sat_preload = 1'b1;
      #1;
      release dut.pc_q;
      @(posedge clk);
      #2;
      sat_preload = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.clkhf_powerup_req = 1'b1;
         wait_sig("sat_pu_rise", 0, 1'b1, 20, i0);
         bus.clkhf_powerup_req = 1'b0;
         wait_sig("sat_pu_fall2", 0, 1'b0, 30, i0);
      end
      chk("pc_saturated", bus.power_cycles, 16'hFFFF);

      // reset mid-GATE
      bus.clkhf_powerup_req = 1'b1;
      wait_sig("rst_en_rise", 1, 1'b1, 30, i0);
      bus.clkhf_powerup_req = 1'b0;
      wait_sig("rst_en_fall", 1, 1'b0, 20, i0);
      chk("rst_in_gate_busy", bus.seq_busy, 1);
      reset = 1'b1;
      step(1);
      chk("rst_gate_hf_pu", bus.hf_pu, 0);
      chk("rst_gate_busy", bus.seq_busy, 0);
      chk("rst_gate_pc", bus.power_cycles, 0);
      reset = 1'b0;
      step(2);

      // random traffic against the model
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 29) == 0) reset = 1'b1;
         bus.clkhf_powerup_req = ($urandom_range(0, 3) != 0);
         bus.clkhf_enable_req  = $urandom_range(0, 1) != 0;
         hold = $urandom_range(1, 12);
         step(hold);
         reset = 1'b0;
      end

      step(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
